// File: rtl/simon_sequence_ctrl_if.sv
// Handshake bundle between the Simon round sequencer and its environment
// (pattern source, pattern shifter, button input, LED/display stage).
interface simon_sequence_ctrl_if #(
  parameter int unsigned MAX_LEN = 8
);
  logic                   start;
  logic [2*MAX_LEN-1:0]   pattern_in;
  logic                   btn_valid;
  logic [1:0]             btn_color;
  logic [1:0]             compare;
  logic                   load_p;
  logic                   next;
  logic [2*MAX_LEN-1:0]   pattern_out;
  logic                   show_en;
  logic [1:0]             show_color;
  logic [3:0]             level;
  logic                   busy;
  logic                   win;
  logic                   lose;

  modport master (
    output start, pattern_in, btn_valid, btn_color, compare,
    input  load_p, next, pattern_out, show_en, show_color, level, busy, win, lose
  );

  modport slave (
    input  start, pattern_in, btn_valid, btn_color, compare,
    output load_p, next, pattern_out, show_en, show_color, level, busy, win, lose
  );
endinterface

// File: rtl/simon_sequence_ctrl.sv
// Simon round sequencer: plays the growing pattern prefix, then checks the
// player's presses against the shifter output, reporting win or lose.
module simon_sequence_ctrl #(
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned SHOW_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 12500000
) (
  input  logic                 clk,
  input  logic                 resetn,
  simon_sequence_ctrl_if.slave bus
);

  localparam int unsigned PW   = 2 * MAX_LEN;
  localparam int unsigned TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 32'd1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 32'd1);
  localparam logic [3:0]    LEVEL_MAX = 4'(MAX_LEN);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD_SHOW  = 4'd1,
    S_SHOW_NEXT  = 4'd2,
    S_SHOW_LATCH = 4'd3,
    S_SHOW_ON    = 4'd4,
    S_SHOW_GAP   = 4'd5,
    S_LOAD_IN    = 4'd6,
    S_IN_NEXT    = 4'd7,
    S_WAIT_IN    = 4'd8,
    S_ROUND_OK   = 4'd9,
    S_WIN        = 4'd10,
    S_LOSE       = 4'd11
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [TW-1:0]   timer_q;
  logic [3:0]      level_q;
  logic [PW-1:0]   pattern_q;
  logic            load_p_q;
  logic            next_q;
  logic            show_en_q;
  logic [1:0]      show_color_q;
  logic            busy_q;
  logic            win_q;
  logic            lose_q;
  logic            last_idx_s;

  assign last_idx_s = (4'(idx_q) == (level_q - 4'd1));

  // Round sequencer; load_p/next are asserted on the transition into the
  // state that owns them so they appear exactly for that state's cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      idx_q        <= {IW{1'b0}};
      timer_q      <= {TW{1'b0}};
      level_q      <= 4'd0;
      pattern_q    <= {PW{1'b0}};
      load_p_q     <= 1'b0;
      next_q       <= 1'b0;
      show_en_q    <= 1'b0;
      show_color_q <= 2'b00;
      busy_q       <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      load_p_q <= 1'b0;
      next_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: begin
          if (bus.start) begin
            pattern_q <= bus.pattern_in;
            level_q   <= 4'd1;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            busy_q    <= 1'b1;
            load_p_q  <= 1'b1;
            state_q   <= S_LOAD_SHOW;
          end
        end
        S_LOAD_SHOW: begin
          idx_q   <= {IW{1'b0}};
          next_q  <= 1'b1;
          state_q <= S_SHOW_NEXT;
        end
        S_SHOW_NEXT: begin
          state_q <= S_SHOW_LATCH;
        end
        // compare is valid here, one cycle after the next pulse
        S_SHOW_LATCH: begin
          show_color_q <= bus.compare;
          show_en_q    <= 1'b1;
          timer_q      <= {TW{1'b0}};
          state_q      <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (timer_q == SHOW_LAST) begin
            show_en_q <= 1'b0;
            timer_q   <= {TW{1'b0}};
            state_q   <= S_SHOW_GAP;
          end else begin
            timer_q <= timer_q + TW'(1'b1);
          end
        end
        S_SHOW_GAP: begin
          if (timer_q == GAP_LAST) begin
            timer_q <= {TW{1'b0}};
            if (last_idx_s) begin
              load_p_q <= 1'b1;
              state_q  <= S_LOAD_IN;
            end else begin
              idx_q   <= idx_q + IW'(1'b1);
              next_q  <= 1'b1;
              state_q <= S_SHOW_NEXT;
            end
          end else begin
            timer_q <= timer_q + TW'(1'b1);
          end
        end
        S_LOAD_IN: begin
          idx_q   <= {IW{1'b0}};
          next_q  <= 1'b1;
          state_q <= S_IN_NEXT;
        end
        S_IN_NEXT: begin
          state_q <= S_WAIT_IN;
        end
        S_WAIT_IN: begin
          if (bus.btn_valid) begin
            if (bus.btn_color != bus.compare) begin
              lose_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_LOSE;
            end else if (last_idx_s) begin
              state_q <= S_ROUND_OK;
            end else begin
              idx_q   <= idx_q + IW'(1'b1);
              next_q  <= 1'b1;
              state_q <= S_IN_NEXT;
            end
          end
        end
        S_ROUND_OK: begin
          if (level_q == LEVEL_MAX) begin
            win_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_WIN;
          end else begin
            level_q  <= level_q + 4'd1;
            load_p_q <= 1'b1;
            state_q  <= S_LOAD_SHOW;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.load_p      = load_p_q;
  assign bus.next        = next_q;
  assign bus.pattern_out = pattern_q;
  assign bus.show_en     = show_en_q;
  assign bus.show_color  = show_color_q;
  assign bus.level       = level_q;
  assign bus.busy        = busy_q;
  assign bus.win         = win_q;
  assign bus.lose        = lose_q;

endmodule

// File: tb/tb_simon_sequence_ctrl.sv
// Scoreboard bench for simon_sequence_ctrl: a player process drives random
// games while a monitor checks playback, timing and outcome events.
module tb_simon_sequence_ctrl;
  localparam int MAX_LEN = 4;
  localparam int SHOW    = 3;
  localparam int GAP     = 2;
  localparam int PW      = 2 * MAX_LEN;
  localparam int K_SHOW  = 0;
  localparam int K_WIN   = 1;
  localparam int K_LOSE  = 2;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  simon_sequence_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

  simon_sequence_ctrl #(
    .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  typedef struct { int kind; logic [1:0] color; logic [3:0] lvl; } exp_t;
  exp_t expq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // colour k of a pattern, colour 0 in the top bits
  function automatic logic [1:0] col(input logic [PW-1:0] p, input int k);
    logic [PW-1:0] t;
    t = p << (2 * k);
    return t[PW-1 -: 2];
  endfunction

  // Pattern shifter model: compare becomes valid the cycle after next.
  logic [PW-1:0] shreg;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg       <= '0;
      bus.compare <= 2'b00;
    end else if (bus.load_p) begin
      shreg <= bus.pattern_out;
    end else if (bus.next) begin
      bus.compare <= shreg[PW-1 -: 2];
      shreg       <= shreg << 2;
    end
  end

  task automatic pop_check(input int kind, input logic [1:0] c, input logic [3:0] l);
    exp_t e;
    if (expq.size() == 0) begin
      chk("unexpected_event", kind, -1);
      return;
    end
    e = expq.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind == K_SHOW) chk("show_color", int'(c), int'(e.color));
    chk("event_level", int'(l), int'(e.lvl));
  endtask

  // Monitor: pops expected events on output edges and checks lit/dark timing.
  logic prev_show = 1'b0, prev_win = 1'b0, prev_lose = 1'b0;
  int   run = 0, dark = 0;
  bit   armed = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_show = 1'b0; prev_win = 1'b0; prev_lose = 1'b0;
      run = 0; dark = 0; armed = 1'b0;
    end else begin
      chk("load_next_excl", int'(bus.load_p & bus.next), 0);
      if (bus.show_en && !prev_show) pop_check(K_SHOW, bus.show_color, bus.level);
      if (bus.win && !prev_win)      pop_check(K_WIN, 2'b00, bus.level);
      if (bus.lose && !prev_lose)    pop_check(K_LOSE, 2'b00, bus.level);
      if (armed && bus.load_p) begin
        chk("gap_before_input", dark, GAP);
        armed = 1'b0;
      end else if (armed && bus.show_en) begin
        chk("gap_between_colours", dark, GAP + 2);
        armed = 1'b0;
      end else if (armed) begin
        dark++;
      end
      if (bus.show_en) begin
        run++;
      end else if (prev_show) begin
        chk("show_length", run, SHOW);
        run = 0; armed = 1'b1; dark = 1;
      end
      prev_show = bus.show_en; prev_win = bus.win; prev_lose = bus.lose;
    end
  end

  task automatic push_shows(input logic [PW-1:0] pat, input int r);
    for (int k = 0; k < r; k++) expq.push_back('{K_SHOW, col(pat, k), 4'(r)});
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (expq.size() == 0) break;
    end
    chk("queue_drained", expq.size(), 0);
  endtask

  // Waits for the next load_p, optionally injecting stray presses / a busy start.
  task automatic wait_load(input bit inject, input bit start_busy, input logic [PW-1:0] pat,
                           output bit ok);
    bit did = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.load_p) begin
        bus.btn_valid = 1'b0; bus.start = 1'b0; bus.pattern_in = pat;
        ok = 1'b1;
        return;
      end
      if (inject && $urandom_range(0, 3) == 0) begin
        bus.btn_valid = 1'b1;
        bus.btn_color = 2'($urandom_range(0, 3));
      end else begin
        bus.btn_valid = 1'b0;
      end
      if (start_busy && bus.show_en && !did) begin
        bus.start = 1'b1; bus.pattern_in = ~pat; did = 1'b1;
      end else begin
        bus.start = 1'b0; bus.pattern_in = pat;
      end
    end
    bus.btn_valid = 1'b0; bus.start = 1'b0;
    chk("timeout_load_p", 0, 1);
  endtask

  task automatic press(input logic [1:0] c, input int n);
    repeat (n) @(negedge clk);
    bus.btn_valid = 1'b1; bus.btn_color = c;
    @(posedge clk); #1;
    bus.btn_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_load_p"}, int'(bus.load_p), 0);
    chk({tag, "_next"}, int'(bus.next), 0);
    chk({tag, "_pattern_out"}, int'(bus.pattern_out), 0);
    chk({tag, "_show_en"}, int'(bus.show_en), 0);
    chk({tag, "_show_color"}, int'(bus.show_color), 0);
    chk({tag, "_level"}, int'(bus.level), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_win"}, int'(bus.win), 0);
    chk({tag, "_lose"}, int'(bus.lose), 0);
  endtask

  task automatic do_reset(input int r);
    bit seen = 1'b0;
    repeat (2) @(negedge clk);
    chk("level_before_reset", int'(bus.level), r);
    resetn = 1'b0;
    #1;
    check_zero_outputs("midreset");
    expq.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.load_p || bus.next || bus.busy) seen = 1'b1;
    end
    chk("idle_after_reset", int'(seen), 0);
  endtask

  task automatic check_lose(input int r, input logic [PW-1:0] pat);
    drain();
    chk("lose_flag", int'(bus.lose), 1);
    chk("lose_busy", int'(bus.busy), 0);
    chk("lose_level", int'(bus.level), r);
    chk("lose_win", int'(bus.win), 0);
    for (int i = 0; i < 3; i++) press(2'($urandom_range(0, 3)), 2);
    repeat (3) @(negedge clk);
    chk("lose_held", int'(bus.lose), 1);
    chk("lose_level_held", int'(bus.level), r);
    chk("lose_pattern_held", int'(bus.pattern_out), int'(pat));
    chk("lose_idle", int'(bus.busy), 0);
  endtask

  task automatic play_game(input logic [PW-1:0] pat, input int bad_round, input int bad_pos,
                           input logic [1:0] bad_xor, input int abort_round, input bit start_busy);
    bit ok;
    logic [1:0] c;
    push_shows(pat, 1);
    @(negedge clk);
    bus.pattern_in = pat; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int r = 1; r <= MAX_LEN; r++) begin
      wait_load(1'b0, 1'b0, pat, ok);
      if (!ok) return;
      chk("round_level", int'(bus.level), r);
      chk("round_pattern", int'(bus.pattern_out), int'(pat));
      chk("round_busy", int'(bus.busy), 1);
      if (r == 1) chk("start_clears_flags", int'({bus.win, bus.lose}), 0);
      wait_load(1'b1, start_busy && (r == 2), pat, ok);
      if (!ok) return;
      chk("input_pattern_held", int'(bus.pattern_out), int'(pat));
      for (int k = 0; k < r; k++) begin
        c = col(pat, k);
        if (r == abort_round && k == 1) begin
          do_reset(r);
          return;
        end
        if (r == bad_round && k == bad_pos) begin
          c = c ^ bad_xor;
          expq.push_back('{K_LOSE, 2'b00, 4'(r)});
        end else if (k == r - 1) begin
          if (r == MAX_LEN) expq.push_back('{K_WIN, 2'b00, 4'(MAX_LEN)});
          else push_shows(pat, r + 1);
        end
        press(c, 2 + int'($urandom_range(0, 2)));
        if (r == bad_round && k == bad_pos) begin
          check_lose(r, pat);
          return;
        end
      end
    end
    drain();
    chk("win_flag", int'(bus.win), 1);
    chk("win_busy", int'(bus.busy), 0);
    chk("win_lose", int'(bus.lose), 0);
    chk("win_level", int'(bus.level), MAX_LEN);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int br, bp;
    bus.start = 1'b0; bus.pattern_in = '0; bus.btn_valid = 1'b0; bus.btn_color = 2'b00;
    #1;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    play_game(8'b00_01_10_11, 0, 0, 2'b00, 0, 1'b1);
    play_game(8'b00_01_10_11, 2, 1, 2'b10, 0, 1'b0);
    play_game(PW'($urandom()), 0, 0, 2'b00, 0, 1'b0);
    for (int g = 0; g < 4; g++) begin
      br = int'($urandom_range(0, MAX_LEN));
      bp = (br > 0) ? int'($urandom_range(0, br - 1)) : 0;
      play_game(PW'($urandom()), br, bp, 2'($urandom_range(1, 3)), 0, 1'b0);
    end
    play_game(PW'($urandom()), 0, 0, 2'b00, 3, 1'b0);
    play_game(PW'($urandom()), 0, 0, 2'b00, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
